// File: rtl/reset_sequencer.sv
// Reset sequencer: async-assert / sync-deassert reset with hold filter and
// staggered per-channel release, plus a software-triggered re-sequence.
// Ports: clk, reset (async, active-high board reset), sw_reset_req (sync
//   request, honoured only once all channels are released), s_reset[NUM_CH]
//   (per-channel resets, bit 0 first), ready (all released), sw_count
//   (saturating count of accepted software resets).
// Latency: s_reset[i] falls SYNC_STAGES + HOLD_CYCLES + i*STAGGER edges after
//   reset is first sampled low; all outputs are registered.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int NUM_CH      = 3,
  parameter int STAGGER     = 2,
  parameter int SW_PULSE    = 3,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sw_reset_req,
  output logic [NUM_CH-1:0] s_reset,
  output logic              ready,
  output logic [CNT_W-1:0]  sw_count
);

  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int STAG_W  = $clog2(STAGGER + 1);
  localparam int PULSE_W = $clog2(SW_PULSE + 1);
  localparam int CH_W    = $clog2(NUM_CH + 1);

  typedef enum logic [1:0] {ST_HOLD, ST_RELEASE, ST_RUN, ST_SWRST} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [STAG_W-1:0]      stag_cnt_q, stag_cnt_d;
  logic [PULSE_W-1:0]     pulse_cnt_q, pulse_cnt_d;
  logic [CH_W-1:0]        ch_idx_q, ch_idx_d;
  logic [NUM_CH-1:0]      s_reset_q, s_reset_d;
  logic                   ready_q, ready_d;
  logic [CNT_W-1:0]       sw_count_q, sw_count_d;
  logic                   rst_sync;

  assign rst_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], 1'b0};
    hold_cnt_d  = hold_cnt_q;
    stag_cnt_d  = stag_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    ch_idx_d    = ch_idx_q;
    s_reset_d   = s_reset_q;
    ready_d     = ready_q;
    sw_count_d  = sw_count_q;

    case (state_q)
      ST_HOLD: begin
        if (rst_sync) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          hold_cnt_d = '0;
          stag_cnt_d = '0;
          // Channels release in index order, so shifting in zeros from the
          // bottom clears exactly the next channel.
          s_reset_d  = s_reset_q << 1;
          ch_idx_d   = CH_W'(1);
          if (NUM_CH == 1) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      ST_RELEASE: begin
        if (stag_cnt_q == STAG_W'(STAGGER - 1)) begin
          stag_cnt_d = '0;
          s_reset_d  = s_reset_q << 1;
          ch_idx_d   = ch_idx_q + CH_W'(1);
          if (ch_idx_q == CH_W'(NUM_CH - 1)) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end
        end else begin
          stag_cnt_d = stag_cnt_q + STAG_W'(1);
        end
      end

      ST_RUN: begin
        s_reset_d = '0;
        ready_d   = 1'b1;
        if (sw_reset_req) begin
          s_reset_d   = '1;
          ready_d     = 1'b0;
          pulse_cnt_d = '0;
          state_d     = ST_SWRST;
          if (sw_count_q != '1) sw_count_d = sw_count_q + CNT_W'(1);
        end
      end

      ST_SWRST: begin
        // Entry edge counts as the first pulse edge; the HOLD phase then
        // starts counting at once because the synchroniser is already low.
        if (pulse_cnt_q == PULSE_W'(SW_PULSE - 1)) begin
          pulse_cnt_d = '0;
          hold_cnt_d  = '0;
          state_d     = ST_HOLD;
        end else begin
          pulse_cnt_d = pulse_cnt_q + PULSE_W'(1);
        end
      end

      default: state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      sync_q      <= '1;
      hold_cnt_q  <= '0;
      stag_cnt_q  <= '0;
      pulse_cnt_q <= '0;
      ch_idx_q    <= '0;
      s_reset_q   <= '1;
      ready_q     <= 1'b0;
      sw_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      hold_cnt_q  <= hold_cnt_d;
      stag_cnt_q  <= stag_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      ch_idx_q    <= ch_idx_d;
      s_reset_q   <= s_reset_d;
      ready_q     <= ready_d;
      sw_count_q  <= sw_count_d;
    end
  end

  assign s_reset  = s_reset_q;
  assign ready    = ready_q;
  assign sw_count = sw_count_q;

endmodule
